// File: rtl/matmul_seq_ctrl_if.sv
// Host-side bundle for the sequential 3x3 matrix multiplier: operands in,
// start/busy/done handshake, registered result out.
interface matmul_seq_ctrl_if #(
  parameter int DATA_W = 8
);
  logic                start;
  logic [9*DATA_W-1:0] a_flat;
  logic [9*DATA_W-1:0] b_flat;
  logic [9*DATA_W-1:0] c_flat;
  logic                busy;
  logic                done;

  // Handshake: start is sampled only while busy=0; busy stays high from the
  // accepting edge until the edge that leaves DONE; done pulses one cycle and
  // marks c_flat valid, which then holds until the next completion or reset.
  modport master (
    output start, a_flat, b_flat,
    input  c_flat, busy, done
  );

  modport slave (
    input  start, a_flat, b_flat,
    output c_flat, busy, done
  );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Time-shared 3x3 matrix multiply: one MAC per cycle over an (i,j,k) schedule,
// 27 terms, with the nine results published together at completion.
module matmul_seq_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  matmul_seq_ctrl_if.slave   bus,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int FW = 9 * DATA_W;

  state_e            state_q, state_d;
  logic [FW-1:0]     a_q, a_d;
  logic [FW-1:0]     b_q, b_d;
  logic [FW-1:0]     shadow_q, shadow_d;
  logic [FW-1:0]     c_q, c_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [1:0]        i_q, i_d;
  logic [1:0]        j_q, j_d;
  logic [1:0]        k_q, k_d;

  logic [3:0]        a_idx, b_idx, s_idx;
  logic [DATA_W-1:0] a_el, b_el, term, sum;
  logic              last_term;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      c_q      <= '0;
      acc_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      shadow_q <= shadow_d;
      c_q      <= c_d;
      acc_q    <= acc_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
    end
  end

  // Operand selection for the current term a[i][k] * b[k][j].
  always_comb begin
    a_idx     = 4'({2'b00, i_q} * 4'd3 + {2'b00, k_q});
    b_idx     = 4'({2'b00, k_q} * 4'd3 + {2'b00, j_q});
    s_idx     = 4'({2'b00, i_q} * 4'd3 + {2'b00, j_q});
    a_el      = a_q[a_idx*DATA_W +: DATA_W];
    b_el      = b_q[b_idx*DATA_W +: DATA_W];
    term      = a_el * b_el;
    sum       = acc_q + term;
    last_term = (i_q == 2'd2) && (j_q == 2'd2) && (k_q == 2'd2);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    shadow_d = shadow_q;
    c_d      = c_q;
    acc_d    = acc_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a_flat;
          b_d     = bus.b_flat;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (k_q == 2'd0) begin
          acc_d = term;
        end else if (k_q == 2'd1) begin
          acc_d = sum;
        end else begin
          shadow_d[s_idx*DATA_W +: DATA_W] = sum;
          acc_d = '0;
        end
        if (k_q == 2'd2) begin
          k_d = '0;
          if (j_q == 2'd2) begin
            j_d = '0;
            i_d = i_q + 2'd1;
          end else begin
            j_d = j_q + 2'd1;
          end
        end else begin
          k_d = k_q + 2'd1;
        end
        // Slot 8 lands in shadow_d this same edge, so publish shadow_d.
        if (last_term) begin
          c_d     = shadow_d;
          i_d     = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (state_q == S_RUN) || (state_q == S_DONE);
    bus.done    = (state_q == S_DONE);
    bus.c_flat  = c_q;
    dbg_state_o = state_q;
  end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
Sequencing controller for the 3x3 matrix-multiply datapath. It replaces the fully unrolled 27-MAC array with one time-shared multiply-accumulate stage. On start it captures A and B, steps a row/column/term schedule through the shared MAC for 27 cycles, and presents all nine products at once with a one-cycle done pulse. It sits between the host-side operand registers and the result consumers, and owns the start/busy/done handshake.

Parameters:
DATA_W, 8, element width for A, B and C; all arithmetic is modulo 2^DATA_W.

Ports:
clk  input  1  single clock; all state changes on rising edge
reset  input  1  asynchronous, active-low; 0 forces reset state immediately
start  input  1  request; sampled only in IDLE
a_flat  input  9*DATA_W  matrix A; element a[r][c] at bits [(3r+c)*DATA_W +: DATA_W]
b_flat  input  9*DATA_W  matrix B; same packing as a_flat
c_flat  output  9*DATA_W  result C = A x B; same packing; registered
busy  output  1  high from the edge that accepts start until the edge that ends DONE
done  output  1  one-cycle pulse; c_flat valid and stable from this cycle on

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0; done=0; c_flat=0; operand, accumulator and index registers=0. Reset mid-run discards the run. No done pulse is produced and c_flat reads 0.
- States:
  - IDLE: busy=0. start=1 at an edge -> capture a_flat/b_flat into internal copies, i=j=k=0, acc=0, go to RUN.
  - RUN: one term per cycle, 27 cycles.
  - DONE: one cycle, done=1, then IDLE.
- RUN schedule: term order is row i outer, column j middle, k inner (i,j,k each 0..2). Each edge computes term = a[i][k]*b[k][j], truncated to DATA_W bits.
  - k=0: acc <= term.
  - k=1: acc <= acc + term.
  - k=2: the element value (acc + term) is written to shadow slot 3i+j. acc is not carried into the next element.
  - All sums wrap modulo 2^DATA_W; no saturation, no overflow flag.
- Index advance: k wraps 2->0 and increments j; j wraps 2->0 and increments i. On the edge processing (i,j,k)=(2,2,2), the shadow register including slot 8 is copied to c_flat, and the state goes to DONE.
- Latency: start accepted at edge E0; term n (0..26) is processed at edge E(n+1); c_flat updates and done rises at E27; done falls and busy falls at E28. busy is high for exactly 28 cycles and done for exactly 1.
- c_flat changes only at the completion edge or on reset. It holds the previous result throughout the next run, so no partial results are ever visible.
- Changes on a_flat/b_flat during RUN/DONE are ignored, because internal copies are used.
- start while busy (RUN or DONE) is ignored; it is not queued. If start is held high continuously, the next run is accepted at the first edge in IDLE (E29), giving back-to-back throughput of one result per 29 cycles.
- reset low coincident with a clock edge: reset wins.
- An unreachable state encoding returns to IDLE with busy=0 and done=0.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release, no start -> c_flat=0, busy=0, done=0 for 50 cycles.
- Known product: A=[1..9] row-major, B=[9..1] row-major, start one cycle -> done exactly 27 cycles after the accepting edge. c_flat = {30,24,18,84,69,54,138,114,90} in slot order 0..8. busy high for exactly 28 cycles.
- Wrap-around: all A and B elements 0xFF -> every C element 0x03 (3*0xFE01 mod 256). Identity A with B=[1..9] -> C=B.
- Operand/start interference: change a_flat to all zeros and pulse start at cycle 5 of RUN -> result still matches the captured operands, exactly one done pulse, no second run.
- Reset mid-run: reset=0 asynchronously at cycle 10 of RUN -> busy and done drop immediately and c_flat=0. A new start after release gives the correct result 27 cycles later.
- Back-to-back: start held high, operands switched between runs -> two done pulses 29 cycles apart. c_flat holds result 1 until the second completion edge, then shows result 2.
